// File: rtl/counter_seq_checker_if.sv
// Interface bundling the checker's control inputs, observed count bus and
// result flags. The master side drives q and the controls; the slave side is
// the checker itself.
interface counter_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             en;
  logic             dut_reset;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic             locked;
  logic             error;
  logic             error_sticky;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] wrap_count;
  logic [WIDTH-1:0] expected;

  modport master (
    output en, dut_reset, clr, q,
    input  locked, error, error_sticky, err_count, wrap_count, expected
  );

  modport slave (
    input  en, dut_reset, clr, q,
    output locked, error, error_sticky, err_count, wrap_count, expected
  );
endinterface

// File: rtl/counter_seq_checker.sv
// Response-side checker for a free-running binary up-counter. Locks onto the
// observed sequence, then flags any step that is not +1 mod 2^WIDTH, counting
// errors and wrap-arounds (both saturating).
// Optional build macro COUNTER_SEQ_CHECKER_HOLD_ALLOW_EN: when defined, a
// repeat of the previous value while locked is accepted as a stall.
module counter_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input logic                   clk,
  input logic                   reset,
  counter_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    LOCK  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] CNT1   = ERR_W'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] expected, expected_n;
  logic [3:0]       mcnt, mcnt_n, mcnt_inc;
  logic             error, error_n;
  logic             sticky, sticky_n;
  logic [ERR_W-1:0] err_cnt, err_cnt_n, err_base;
  logic [ERR_W-1:0] wrap_cnt, wrap_cnt_n, wrap_base;
  logic             hit_err, hit_wrap, stall;

  assign mcnt_inc = mcnt + 4'd1;

`ifdef COUNTER_SEQ_CHECKER_HOLD_ALLOW_EN
  assign stall = (bus.q == expected - ONE);
`else
  assign stall = 1'b0;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      expected <= '0;
      mcnt     <= '0;
      error    <= 1'b0;
      sticky   <= 1'b0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      state    <= state_n;
      expected <= expected_n;
      mcnt     <= mcnt_n;
      error    <= error_n;
      sticky   <= sticky_n;
      err_cnt  <= err_cnt_n;
      wrap_cnt <= wrap_cnt_n;
    end
  end

  // Next-state, compare and counter update logic
  always_comb begin
    state_n    = state;
    expected_n = expected;
    mcnt_n     = mcnt;
    hit_err    = 1'b0;
    hit_wrap   = 1'b0;

    if (bus.dut_reset) begin
      state_n    = ACQ;
      expected_n = '0;
      mcnt_n     = '0;
    end else if (!bus.en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          expected_n = bus.q + ONE;
          mcnt_n     = '0;
          state_n    = ACQ;
        end
        ACQ: begin
          if (bus.q == expected) begin
            expected_n = expected + ONE;
            mcnt_n     = mcnt_inc;
            if (mcnt_inc == LOCK_N) state_n = LOCK;
          end else begin
            expected_n = bus.q + ONE;
            mcnt_n     = '0;
          end
        end
        LOCK: begin
          if (bus.q == expected) begin
            expected_n = expected + ONE;
            hit_wrap   = (bus.q == '1);
          end else if (!stall) begin
            hit_err = 1'b1;
            state_n = FAULT;
          end
        end
        FAULT: begin
          expected_n = bus.q + ONE;
          mcnt_n     = '0;
          state_n    = ACQ;
        end
        default: state_n = IDLE;
      endcase
    end

    // clr zeroes the base first so an increment on the same edge still lands
    error_n    = hit_err;
    sticky_n   = hit_err | (sticky & ~bus.clr);
    err_base   = bus.clr ? '0 : err_cnt;
    wrap_base  = bus.clr ? '0 : wrap_cnt;
    err_cnt_n  = (hit_err  && err_base  != '1) ? err_base  + CNT1 : err_base;
    wrap_cnt_n = (hit_wrap && wrap_base != '1) ? wrap_base + CNT1 : wrap_base;
  end

  assign bus.locked       = (state == LOCK);
  assign bus.error        = error;
  assign bus.error_sticky = sticky;
  assign bus.err_count    = err_cnt;
  assign bus.wrap_count   = wrap_cnt;
  assign bus.expected     = expected;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker: a vector table for the main
// lock / wrap / fault / relock flow, plus hand sequences for dut_reset,
// clr interaction, err_count saturation, the optional stall and async reset.
module tb_counter_seq_checker;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  counter_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus ();

  counter_seq_checker #(
    .WIDTH(4),
    .LOCK_CNT(4),
    .ERR_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       dr;
    logic       clr;
    logic [3:0] q;
    logic       lk;
    logic       er;
    logic       st;
    logic [7:0] ec;
    logic [7:0] wc;
    logic [3:0] ex;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic en, logic dr, logic clr, logic [3:0] q,
                              logic lk, logic er, logic st, logic [7:0] ec,
                              logic [7:0] wc, logic [3:0] ex);
    vec_t v;
    v.en = en; v.dr = dr; v.clr = clr; v.q = q;
    v.lk = lk; v.er = er; v.st = st; v.ec = ec; v.wc = wc; v.ex = ex;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic dr, input logic clr, input logic [3:0] q);
    bus.en = en; bus.dut_reset = dr; bus.clr = clr; bus.q = q;
  endtask

  // Packs {locked,error,sticky,err_count,wrap_count,expected}
  function automatic logic [31:0] outs();
    return {9'd0, bus.locked, bus.error, bus.error_sticky,
            bus.err_count, bus.wrap_count, bus.expected};
  endfunction

  function automatic logic [31:0] pack(logic lk, logic er, logic st, logic [7:0] ec,
                                       logic [7:0] wc, logic [3:0] ex);
    return {9'd0, lk, er, st, ec, wc, ex};
  endfunction

  // One forced error: reseed via dut_reset, lock on 0..3, then break on 9
  task automatic err_one();
    drive(1'b1, 1'b1, 1'b0, 4'd0); step();
    for (int v = 0; v <= 3; v++) begin
      drive(1'b1, 1'b0, 1'b0, 4'(v)); step();
    end
    drive(1'b1, 1'b0, 1'b0, 4'd9); step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0);

    // Table: lock from 11, wrap once, fault on 9, relock, disable, reseed
    add(1, 0, 0, 4'd11, 0, 0, 0, 8'd0, 8'd0, 4'd12);
    for (int v = 12; v <= 14; v++) add(1, 0, 0, 4'(v), 0, 0, 0, 8'd0, 8'd0, 4'(v + 1));
    add(1, 0, 0, 4'd15, 1, 0, 0, 8'd0, 8'd0, 4'd0);
    for (int v = 0; v <= 15; v++) add(1, 0, 0, 4'(v), 1, 0, 0, 8'd0, 8'((v == 15) ? 1 : 0), 4'(v + 1));
    for (int v = 0; v <= 6; v++) add(1, 0, 0, 4'(v), 1, 0, 0, 8'd0, 8'd1, 4'(v + 1));
    add(1, 0, 0, 4'd9, 0, 1, 1, 8'd1, 8'd1, 4'd7);
    add(1, 0, 0, 4'd10, 0, 0, 1, 8'd1, 8'd1, 4'd11);
    for (int v = 11; v <= 13; v++) add(1, 0, 0, 4'(v), 0, 0, 1, 8'd1, 8'd1, 4'(v + 1));
    add(1, 0, 0, 4'd14, 1, 0, 1, 8'd1, 8'd1, 4'd15);
    add(0, 0, 0, 4'd3, 0, 0, 1, 8'd1, 8'd1, 4'd15);
    add(1, 0, 0, 4'd7, 0, 0, 1, 8'd1, 8'd1, 4'd8);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), pack(0, 0, 0, 8'd0, 8'd0, 4'd0));
    @(negedge clk);
    reset = 1'b1;
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].dr, vecs[i].clr, vecs[i].q);
      step();
      chk($sformatf("vec%0d", i), outs(),
          pack(vecs[i].lk, vecs[i].er, vecs[i].st, vecs[i].ec, vecs[i].wc, vecs[i].ex));
    end

    // dut_reset held 3 cycles: forced to expect 0, no compare
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0); step();
      chk("dr_hold", outs(), pack(0, 0, 1, 8'd1, 8'd1, 4'd0));
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0); step();
    chk("dr_rel_q0", outs(), pack(0, 0, 1, 8'd1, 8'd1, 4'd1));
    drive(1'b1, 1'b0, 1'b0, 4'd1); step();
    drive(1'b1, 1'b0, 1'b0, 4'd2); step();
    chk("dr_rel_q2", {31'd0, bus.locked}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd3); step();
    chk("dr_rel_q3", {31'd0, bus.locked}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 4'd4); step();
    chk("dr_rel_q4", outs(), pack(1, 0, 1, 8'd1, 8'd1, 4'd5));

    // Release with a nonzero value only reseeds
    drive(1'b1, 1'b1, 1'b0, 4'd0); step();
    drive(1'b1, 1'b0, 1'b0, 4'd5); step();
    chk("dr_rel_q5", outs(), pack(0, 0, 1, 8'd1, 8'd1, 4'd6));

    // clr on the same edge as a LOCK mismatch, then clr alone
    for (int v = 6; v <= 9; v++) begin
      drive(1'b1, 1'b0, 1'b0, 4'(v)); step();
    end
    chk("clr_locked", {31'd0, bus.locked}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 4'd3); step();
    chk("clr_with_err", outs(), pack(0, 1, 1, 8'd1, 8'd0, 4'd10));
    drive(1'b1, 1'b0, 1'b1, 4'd4); step();
    chk("clr_alone", outs(), pack(0, 0, 0, 8'd0, 8'd0, 4'd5));
    drive(1'b1, 1'b0, 1'b0, 4'd5); step();

    // err_count saturation
    for (int i = 1; i <= 256; i++) begin
      err_one();
      if (i == 1 || i == 255 || i == 256) begin
        chk($sformatf("sat_err%0d", i), {23'd0, bus.error, bus.err_count},
            {23'd0, 1'b1, 8'((i > 255) ? 255 : i)});
      end
    end

    // Repeated value while locked: stall or error depending on build
    drive(1'b1, 1'b1, 1'b0, 4'd0); step();
    for (int v = 0; v <= 4; v++) begin
      drive(1'b1, 1'b0, 1'b0, 4'(v)); step();
    end
    drive(1'b1, 1'b0, 1'b0, 4'd5); step();
    drive(1'b1, 1'b0, 1'b0, 4'd6); step();
    chk("hold_pre", {30'd0, bus.locked, bus.error}, {30'd0, 2'b10});
    drive(1'b1, 1'b0, 1'b0, 4'd6); step();
`ifdef COUNTER_SEQ_CHECKER_HOLD_ALLOW_EN
    chk("hold_rep6", {24'd0, bus.locked, bus.error, bus.err_count[1:0], bus.expected},
        {24'd0, 1'b1, 1'b0, 2'b11, 4'd7});
    drive(1'b1, 1'b0, 1'b0, 4'd7); step();
    chk("hold_q7", {26'd0, bus.locked, bus.error, bus.expected}, {26'd0, 2'b10, 4'd8});
`else
    chk("hold_rep6", {24'd0, bus.locked, bus.error, bus.err_count[1:0], bus.expected},
        {24'd0, 1'b0, 1'b1, 2'b11, 4'd7});
    drive(1'b1, 1'b0, 1'b0, 4'd7); step();
    chk("hold_q7", {26'd0, bus.locked, bus.error, bus.expected}, {26'd0, 2'b00, 4'd8});
`endif

    // Asynchronous reset mid-operation, between clock edges
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", outs(), pack(0, 0, 0, 8'd0, 8'd0, 4'd0));
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd3); step();
    chk("post_reset_seed", outs(), pack(0, 0, 0, 8'd0, 8'd0, 4'd4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
